// File: rtl/lfsr_engine.sv
// lfsr_engine: counted Fibonacci/Galois LFSR runner; ports clk, rst (async), start, abort, mode, seed, steps -> lfsr_out, busy, done, zero_flag; LFSR_ENGINE_ZERO_GUARD_EN loads a zero seed as 1
module lfsr_engine #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h80200003),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             busy,
  output logic             done,
  output logic             zero_flag
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_n;
  logic [WIDTH-1:0] lfsr, lfsr_n, step_v, seed_v;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic gal, gal_n;
`ifdef LFSR_ENGINE_ZERO_GUARD_EN
  assign seed_v = (seed == '0) ? WIDTH'(1) : seed;
`else
  assign seed_v = seed;
`endif
  assign step_v = gal ? ((lfsr << 1) ^ (lfsr[WIDTH-1] ? TAPS : '0)) : {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  always_comb begin
    st_n = st;
    lfsr_n = lfsr;
    cnt_n = cnt;
    gal_n = gal;
    case (st)
      IDLE: if (start) begin
        lfsr_n = seed_v;
        cnt_n = steps;
        gal_n = mode;
        st_n = (steps != '0) ? RUN : DONE;
      end
      RUN: if (abort) st_n = IDLE;
      else begin
        lfsr_n = step_v;
        cnt_n = cnt - 1'b1;
        st_n = (cnt == CNT_W'(1)) ? DONE : RUN;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      lfsr <= '0;
      cnt <= '0;
      gal <= 1'b0;
    end else begin
      st <= st_n;
      lfsr <= lfsr_n;
      cnt <= cnt_n;
      gal <= gal_n;
    end
  assign lfsr_out = lfsr;
  assign busy = st == RUN;
  assign done = st == DONE;
  assign zero_flag = lfsr == '0;
endmodule
